dcache_store_formatter: RTL and testbench

Store-side counterpart of the load aligner in the writeback stage: converts a store instruction's register value, mask and address into a cache-line-wide write (line address, 512-bit data, 64-bit byte enables) using the same in-line byte ordering the load path decodes. It sits between the dcache tag stage and the dcache data array/store queue. It holds a two-entry output FIFO with valid/ready handshakes on both sides, and raises a registered alignment fault instead of emitting misaligned stores.

---
 rtl/dcache_store_formatter_if.sv | 58 +++++
 rtl/dcache_store_formatter.sv | 132 +++++++++++++
 tb/tb_dcache_store_formatter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_store_formatter_if.sv
// Shared store-formatter types plus the request (st_*) and line-write (sf_*) bundles.
package dcache_store_formatter_pkg;
  localparam int CACHE_LINE_BYTES = 64;
  localparam int VECTOR_LANES     = 16;

  typedef logic [3:0]   subcycle_t;
  typedef logic [3:0]   thread_idx_t;
  typedef logic [511:0] vector_t;

  typedef enum logic [3:0] {
    MEM_B, MEM_BX, MEM_S, MEM_SX, MEM_L, MEM_SYNC, MEM_CONTROL_REG,
    MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM,
    MEM_SCGATH, MEM_SCGATH_M, MEM_SCGATH_IM
  } fmtc_op_t;

  typedef struct packed {
    logic [31:0]  line_addr;
    vector_t      data;
    logic [63:0]  byte_en;
    logic         sync;
    thread_idx_t  thread_idx;
  } sf_entry_t;
endpackage

interface dsf_req_if;
  import dcache_store_formatter_pkg::*;
  logic        st_valid;
  logic        st_ready;
  fmtc_op_t    st_op;
  logic [31:0] st_addr;
  vector_t     st_value;
  logic [15:0] st_mask;
  subcycle_t   st_subcycle;
  thread_idx_t st_thread_idx;

  modport master (output st_valid, st_op, st_addr, st_value, st_mask, st_subcycle,
                  st_thread_idx, input st_ready);
  modport slave  (input st_valid, st_op, st_addr, st_value, st_mask, st_subcycle,
                  st_thread_idx, output st_ready);
endinterface

interface dsf_out_if;
  import dcache_store_formatter_pkg::*;
  logic        sf_valid;
  logic        sf_ready;
  logic [31:0] sf_line_addr;
  vector_t     sf_data;
  logic [63:0] sf_byte_en;
  logic        sf_sync;
  thread_idx_t sf_thread_idx;
  logic        sf_fault;
  thread_idx_t sf_fault_thread_idx;

  modport master (output sf_valid, sf_line_addr, sf_data, sf_byte_en, sf_sync,
                  sf_thread_idx, sf_fault, sf_fault_thread_idx, input sf_ready);
  modport slave  (input sf_valid, sf_line_addr, sf_data, sf_byte_en, sf_sync,
                  sf_thread_idx, sf_fault, sf_fault_thread_idx, output sf_ready);
endinterface

// File: rtl/dcache_store_formatter.sv
// Formats scalar/block/scatter stores into line-wide writes; 1-cycle latency through a
// 2-entry FIFO; st_ready drops when full unless the head pops the same cycle.
module dcache_store_formatter
  import dcache_store_formatter_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  dsf_req_if.slave  st,
  dsf_out_if.master sf
);

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  logic [5:0]  off;
  logic [3:0]  lane_sel;
  logic [31:0] lane_word;
  vector_t     fmt_dat;
  logic [63:0] fmt_be;
  logic        misalign;
  logic        is_ctrl;

  // Byte 0 of the line sits in the top byte lane, so scalar patterns start at the MSB
  // and shift down by the line offset.
  always_comb begin
    fmt_dat   = '0;
    fmt_be    = '0;
    misalign  = 1'b0;
    is_ctrl   = 1'b0;
    off       = st.st_addr[5:0];
    lane_sel  = 4'd15 - st.st_subcycle;
    lane_word = st.st_value[{lane_sel, 5'b0} +: 32];
    case (st.st_op)
      MEM_B, MEM_BX: begin
        fmt_dat = {st.st_value[7:0], 504'b0} >> {off, 3'b000};
        fmt_be  = {1'b1, 63'b0} >> off;
      end
      MEM_S, MEM_SX: begin
        misalign = off[0];
        fmt_dat  = {st.st_value[7:0], st.st_value[15:8], 496'b0} >> {off, 3'b000};
        fmt_be   = {2'b11, 62'b0} >> off;
      end
      MEM_L, MEM_SYNC: begin
        misalign = |off[1:0];
        fmt_dat  = {bswap(st.st_value[31:0]), 480'b0} >> {off, 3'b000};
        fmt_be   = {4'hF, 60'b0} >> off;
      end
      MEM_CONTROL_REG: begin
        is_ctrl = 1'b1;
      end
      MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM: begin
        misalign = |off;
        for (int l = 0; l < VECTOR_LANES; l++) begin
          if (st.st_op == MEM_BLOCK || st.st_mask[l]) begin
            fmt_dat[l*32 +: 32] = bswap(st.st_value[l*32 +: 32]);
            fmt_be[l*4 +: 4]    = 4'hF;
          end
        end
      end
      default: begin
        misalign = |off[1:0];
        if (st.st_mask[lane_sel]) begin
          fmt_dat = {bswap(lane_word), 480'b0} >> {off, 3'b000};
          fmt_be  = {4'hF, 60'b0} >> off;
        end
      end
    endcase
  end

  sf_entry_t   ent_q [2];
  sf_entry_t   ent_d [2];
  sf_entry_t   new_ent;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        fault_q, fault_d;
  thread_idx_t fault_thread_q, fault_thread_d;
  logic        accept, push, pop;

  assign sf.sf_valid = (count_q != 2'd0);
  assign pop         = sf.sf_valid && sf.sf_ready;
  assign st.st_ready = (count_q < 2'd2) || (count_q == 2'd2 && pop);
  assign accept      = st.st_valid && st.st_ready;

  // Alignment is checked before the drop rules, so a misaligned empty-mask store still faults.
  assign push = accept && !misalign && !is_ctrl && (|fmt_be);

  always_comb begin
    new_ent.line_addr  = {st.st_addr[31:6], 6'b0};
    new_ent.data       = fmt_dat;
    new_ent.byte_en    = fmt_be;
    new_ent.sync       = (st.st_op == MEM_SYNC);
    new_ent.thread_idx = st.st_thread_idx;

    ent_d = ent_q;
    if (push) ent_d[wr_ptr_q] = new_ent;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};

    fault_d        = accept && misalign;
    fault_thread_d = fault_d ? st.st_thread_idx : fault_thread_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q          <= '{default: '0};
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      fault_q        <= 1'b0;
      fault_thread_q <= '0;
    end else begin
      ent_q          <= ent_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      fault_q        <= fault_d;
      fault_thread_q <= fault_thread_d;
    end
  end

  assign sf.sf_line_addr        = ent_q[rd_ptr_q].line_addr;
  assign sf.sf_data             = ent_q[rd_ptr_q].data;
  assign sf.sf_byte_en          = ent_q[rd_ptr_q].byte_en;
  assign sf.sf_sync             = ent_q[rd_ptr_q].sync;
  assign sf.sf_thread_idx       = ent_q[rd_ptr_q].thread_idx;
  assign sf.sf_fault            = fault_q;
  assign sf.sf_fault_thread_idx = fault_thread_q;

endmodule

// File: tb/tb_dcache_store_formatter.sv
// Randomised and directed bench for dcache_store_formatter against a byte-addressed line model.
module tb_dcache_store_formatter;
  import dcache_store_formatter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dsf_req_if req_if ();
  dsf_out_if out_if ();

  dcache_store_formatter dut (.clk(clk), .reset(reset), .st(req_if), .sf(out_if));

  int errors = 0;
  int checks = 0;
  int pops_seen = 0;

  typedef struct {
    logic [31:0]  la;
    logic [511:0] d;
    logic [63:0]  be;
    logic         sync;
    logic [3:0]   thr;
  } exp_t;

  exp_t        q[$];
  bit          pend_fault = 0;
  logic [3:0]  pend_thr = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: fill a 64-entry byte array by byte address, then pack with byte 0 at the MSB.
  function automatic void model(input fmtc_op_t op, input logic [31:0] a,
                                input logic [511:0] v, input logic [15:0] m,
                                input logic [3:0] sc, output exp_t e,
                                output bit mis, output bit drop);
    logic [7:0]  bytes [64];
    bit          en [64];
    int          off;
    int          n;
    int          lane;
    logic [31:0] w;
    off = int'(a[5:0]);
    n   = 0;
    w   = v[31:0];
    mis = 0;
    for (int b = 0; b < 64; b++) begin bytes[b] = 8'h00; en[b] = 0; end
    case (op)
      MEM_B, MEM_BX:   n = 1;
      MEM_S, MEM_SX:   begin n = 2; mis = (a % 2) != 0; end
      MEM_L, MEM_SYNC: begin n = 4; mis = (a % 4) != 0; end
      MEM_CONTROL_REG: n = 0;
      MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM: begin
        mis = (a % 64) != 0;
        for (int i = 0; i < 16; i++)
          for (int k = 0; k < 4; k++) begin
            en[4*i+k]    = (op == MEM_BLOCK) || m[15-i];
            bytes[4*i+k] = v[(15-i)*32 + k*8 +: 8];
          end
      end
      default: begin
        lane = 15 - int'(sc);
        mis  = (a % 4) != 0;
        if (m[lane]) begin n = 4; w = v[lane*32 +: 32]; end
      end
    endcase
    for (int k = 0; k < n; k++)
      if (off + k < 64) begin en[off+k] = 1; bytes[off+k] = w[k*8 +: 8]; end
    e.d  = '0;
    e.be = '0;
    for (int b = 0; b < 64; b++)
      if (en[b]) begin e.d[(63-b)*8 +: 8] = bytes[b]; e.be[63-b] = 1'b1; end
    e.la   = {a[31:6], 6'b0};
    e.sync = (op == MEM_SYNC);
    e.thr  = '0;
    drop   = (e.be == 64'd0) || (op == MEM_CONTROL_REG);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   mis, drop, exp_rdy;
    if (!reset) begin
      chk("rst_sf_valid", out_if.sf_valid, 0);
      chk("rst_sf_fault", out_if.sf_fault, 0);
      chk("rst_sf_sync", out_if.sf_sync, 0);
      chk("rst_sf_data", out_if.sf_data, 0);
      chk("rst_sf_byte_en", out_if.sf_byte_en, 0);
      chk("rst_sf_line_addr", out_if.sf_line_addr, 0);
      chk("rst_sf_thread_idx", out_if.sf_thread_idx, 0);
      chk("rst_sf_fault_thread_idx", out_if.sf_fault_thread_idx, 0);
      q.delete();
      pend_fault = 0;
    end else begin
      exp_rdy = (q.size() < 2) || (q.size() == 2 && out_if.sf_ready);
      chk("st_ready", req_if.st_ready, exp_rdy);
      chk("sf_valid", out_if.sf_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("head_line_addr", out_if.sf_line_addr, q[0].la);
        chk("head_data", out_if.sf_data, q[0].d);
        chk("head_byte_en", out_if.sf_byte_en, q[0].be);
        chk("head_sync", out_if.sf_sync, q[0].sync);
        chk("head_thread", out_if.sf_thread_idx, q[0].thr);
      end
      chk("sf_fault", out_if.sf_fault, pend_fault);
      if (pend_fault) chk("sf_fault_thread", out_if.sf_fault_thread_idx, pend_thr);
      pend_fault = 0;
      if (q.size() != 0 && out_if.sf_ready) begin
        void'(q.pop_front());
        pops_seen++;
      end
      if (req_if.st_valid && exp_rdy) begin
        model(req_if.st_op, req_if.st_addr, req_if.st_value, req_if.st_mask,
              req_if.st_subcycle, e, mis, drop);
        e.thr = req_if.st_thread_idx;
        if (mis) begin
          pend_fault = 1;
          pend_thr   = req_if.st_thread_idx;
        end else if (!drop) begin
          q.push_back(e);
        end
      end
    end
  end

  task automatic drive(input fmtc_op_t op, input logic [31:0] a, input logic [511:0] v,
                       input logic [15:0] m, input logic [3:0] sc, input logic [3:0] t);
    req_if.st_op         = op;
    req_if.st_addr       = a;
    req_if.st_value      = v;
    req_if.st_mask       = m;
    req_if.st_subcycle   = sc;
    req_if.st_thread_idx = t;
    req_if.st_valid      = 1'b1;
  endtask

  task automatic wait_acc();
    int n = 0;
    @(negedge clk);
    while (!req_if.st_ready && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: st_ready still 0 after %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    req_if.st_valid = 1'b0;
  endtask

  task automatic send(input fmtc_op_t op, input logic [31:0] a, input logic [511:0] v,
                      input logic [15:0] m, input logic [3:0] sc, input logic [3:0] t);
    drive(op, a, v, m, sc, t);
    wait_acc();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_vec();
    logic [511:0] r;
    for (int l = 0; l < 16; l++) r[l*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    exp_t         e;
    bit           mis, drop, acc_last;
    logic [511:0] v;
    logic [63:0]  head_be;
    logic [511:0] head_d;
    int           p0;
    logic [31:0]  a;

    reset = 1'b1;
    req_if.st_valid = 1'b0;
    req_if.st_op = MEM_B;
    req_if.st_addr = '0;
    req_if.st_value = '0;
    req_if.st_mask = '0;
    req_if.st_subcycle = '0;
    req_if.st_thread_idx = '0;
    out_if.sf_ready = 1'b1;
    #1 reset = 1'b0;
    idle(3);
    reset = 1'b1;

    // Hand-computed anchors for the reference model itself.
    model(MEM_B, 32'h1003, 512'hAB, 16'h0, 4'd0, e, mis, drop);
    chk("mdl_b_be", e.be, 64'h1000_0000_0000_0000);
    chk("mdl_b_byte", e.d[487:480], 8'hAB);
    model(MEM_L, 32'h2004, 512'h1122_3344, 16'h0, 4'd0, e, mis, drop);
    chk("mdl_l_be", e.be, 64'h0F00_0000_0000_0000);
    chk("mdl_l_word", e.d[479:448], 32'h4433_2211);
    model(MEM_L, 32'h2006, 512'h1122_3344, 16'h0, 4'd0, e, mis, drop);
    chk("mdl_l_misalign", mis, 1);
    v = '0;
    v[511:480] = 32'hA1B2_C3D4;
    v[31:0]    = 32'h0102_0304;
    model(MEM_BLOCK_M, 32'h3000, v, 16'h8001, 4'd0, e, mis, drop);
    chk("mdl_blk_be", e.be, 64'hF000_0000_0000_000F);
    chk("mdl_blk_word0", e.d[511:480], 32'hD4C3_B2A1);
    chk("mdl_blk_word15", e.d[31:0], 32'h0403_0201);

    idle(1);
    send(MEM_B, 32'h1003, 512'hAB, 16'h0, 4'd0, 4'd3);
    chk("b_latency_valid", out_if.sf_valid, 1);
    chk("b_line_addr", out_if.sf_line_addr, 32'h1000);
    chk("b_byte_en", out_if.sf_byte_en, 64'h1000_0000_0000_0000);
    chk("b_byte", out_if.sf_data[487:480], 8'hAB);
    send(MEM_L, 32'h2004, 512'h1122_3344, 16'h0, 4'd0, 4'd2);
    chk("l_byte_en", out_if.sf_byte_en, 64'h0F00_0000_0000_0000);
    chk("l_word", out_if.sf_data[479:448], 32'h4433_2211);
    send(MEM_L, 32'h2006, 512'h1122_3344, 16'h0, 4'd0, 4'd5);
    chk("misalign_fault", out_if.sf_fault, 1);
    chk("misalign_thread", out_if.sf_fault_thread_idx, 4'd5);
    chk("misalign_no_valid", out_if.sf_valid, 0);
    send(MEM_BLOCK_M, 32'h3000, v, 16'h8001, 4'd0, 4'd1);
    chk("blk_byte_en", out_if.sf_byte_en, 64'hF000_0000_0000_000F);
    chk("blk_word0", out_if.sf_data[511:480], 32'hD4C3_B2A1);

    idle(2);
    p0 = pops_seen;
    for (int s = 0; s < 16; s++)
      send(MEM_SCGATH_M, 32'h4000 + 32'(s) * 4, rand_vec(), 16'h00FF, 4'(s), 4'd6);
    idle(3);
    chk("scatter_entries", pops_seen - p0, 8);

    // Back-pressure: third request must stall with a stable head.
    out_if.sf_ready = 1'b0;
    p0 = pops_seen;
    send(MEM_L, 32'h6000, rand_vec(), 16'h0, 4'd0, 4'd1);
    send(MEM_SYNC, 32'h6044, rand_vec(), 16'h0, 4'd0, 4'd2);
    drive(MEM_S, 32'h6082, rand_vec(), 16'h0, 4'd0, 4'd3);
    head_be = out_if.sf_byte_en;
    head_d  = out_if.sf_data;
    repeat (3) begin
      @(negedge clk);
      chk("bp_st_ready", req_if.st_ready, 0);
      chk("bp_head_be_stable", out_if.sf_byte_en, head_be);
      chk("bp_head_data_stable", out_if.sf_data, head_d);
    end
    @(posedge clk); #1;
    out_if.sf_ready = 1'b1;
    wait_acc();
    idle(4);
    chk("bp_drained", pops_seen - p0, 3);

    // Reset while full with a request on the bus.
    out_if.sf_ready = 1'b0;
    send(MEM_L, 32'h7000, rand_vec(), 16'h0, 4'd0, 4'd4);
    send(MEM_L, 32'h7004, rand_vec(), 16'h0, 4'd0, 4'd4);
    drive(MEM_L, 32'h7008, rand_vec(), 16'h0, 4'd0, 4'd4);
    #2;
    reset = 1'b0;
    req_if.st_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", out_if.sf_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    out_if.sf_ready = 1'b1;
    send(MEM_B, 32'h5001, 512'hCD, 16'h0, 4'd0, 4'd7);
    chk("post_rst_valid", out_if.sf_valid, 1);
    chk("post_rst_byte_en", out_if.sf_byte_en, 64'h4000_0000_0000_0000);
    chk("post_rst_thread", out_if.sf_thread_idx, 4'd7);

    acc_last = 0;
    for (int i = 0; i < 3000; i++) begin
      out_if.sf_ready = ($urandom_range(0, 3) != 0);
      if (!req_if.st_valid || acc_last) begin
        a = $urandom;
        case ($urandom_range(0, 3))
          0: a[5:0] = 6'd0;
          1: a[1:0] = 2'd0;
          2: a[0]   = 1'b0;
          default: ;
        endcase
        drive(fmtc_op_t'($urandom_range(0, 12)), a, rand_vec(),
              ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        req_if.st_valid = ($urandom_range(0, 4) != 0);
      end
      @(negedge clk);
      acc_last = req_if.st_valid && req_if.st_ready;
      @(posedge clk); #1;
    end
    req_if.st_valid = 1'b0;
    out_if.sf_ready = 1'b1;
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
